// File: rtl/odd_parity_pkg.sv
// Shared definitions for the odd-parity serial receive path: FSM state
// encoding and the fixed line levels of a frame.
package odd_parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/odd_parity_check.sv
// Combinational odd-parity checker: ok=1 when data plus parity bit hold an
// odd number of ones. Width-parameterised so parallel-bus checkers can reuse it.
module odd_parity_check #(
  parameter int N = 8
) (
  input  logic [N-1:0] data,
  input  logic         p,
  output logic         ok
);

  assign ok = ^data ^ p;

endmodule

// File: rtl/odd_parity_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, odd parity
// bit, stop bit. Sampling happens only on bit_en strobes. Every output is a
// flop, so nothing on sin/bit_en reaches an output combinationally.
module odd_parity_frame_rx
  import odd_parity_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  input  logic              bit_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  rx_state_t         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_perr;
  logic              r_ferr;
  logic              r_busy;
  logic              w_ok;

  odd_parity_check #(
    .N (DATA_W)
  ) u_check (
    .data (r_shift),
    .p    (r_par),
    .ok   (w_ok)
  );

  // Frame FSM, bit counter, deserialiser and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (bit_en) begin
        case (r_state)
          IDLE: begin
            if (sin == START_BIT) begin
              r_state <= DATA;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
            end
          end
          DATA: begin
            r_shift[r_cnt] <= sin;
            if (r_cnt == CNT_LAST) begin
              // Counter parks at zero so it never runs past DATA_W-1.
              r_cnt   <= '0;
              r_state <= PARITY;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          PARITY: begin
            r_par   <= sin;
            r_state <= STOP;
          end
          STOP: begin
            // Word is delivered even when an error is flagged.
            r_data  <= r_shift;
            r_perr  <= ~w_ok;
            r_ferr  <= (sin != STOP_BIT);
            r_valid <= 1'b1;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign busy       = r_busy;

endmodule
